// File: rtl/bmp_stream_writer.sv
// bmp_stream_writer: captures one frame of RGB pixels into an internal store,
// then streams it out as a complete 24-bit BMP file (header, bottom-up rows,
// 4-byte row padding) over a valid/ready byte interface.
module bmp_stream_writer #(
  parameter int WIDTH        = 10,
  parameter int HEIGHT       = 5,
  parameter int PIX_PER_BEAT = 2
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      HSYNC,
  input  logic [8*PIX_PER_BEAT-1:0] DATA_R,
  input  logic [8*PIX_PER_BEAT-1:0] DATA_G,
  input  logic [8*PIX_PER_BEAT-1:0] DATA_B,
  input  logic                      byte_ready,
  output logic [7:0]                byte_out,
  output logic                      byte_valid,
  output logic                      byte_last,
  output logic                      write_done,
  output logic                      write_file_done,
  output logic                      overrun
);

  localparam int NPIX      = WIDTH * HEIGHT;
  localparam int ADDR_W    = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int COL_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int ROW_BYTES = ((3 * WIDTH + 3) / 4) * 4;
  localparam int IMG_SIZE  = ROW_BYTES * HEIGHT;
  localparam int FILE_SIZE = 54 + IMG_SIZE;
  localparam int PAD_N     = ROW_BYTES - 3 * WIDTH;
  localparam int PAD_W     = (PAD_N > 1) ? $clog2(PAD_N) : 1;
  localparam bit HAS_PAD   = (PAD_N != 0);

  localparam logic [COL_W-1:0] COL_LAST      = COL_W'(WIDTH - 1);
  localparam logic [COL_W-1:0] COL_LAST_BEAT = COL_W'(WIDTH - PIX_PER_BEAT);
  localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(HEIGHT - 1);
  localparam logic [PAD_W-1:0] PAD_LAST      = PAD_W'(PAD_N - 1);
  localparam logic [5:0]       HDR_LAST      = 6'd53;

  typedef enum logic [1:0] {CAPTURE, HEADER, PIXELS, PAD} state_t;

  state_t              state, state_nxt;
  logic [ROW_W-1:0]    wr_row, rd_row;
  logic [COL_W-1:0]    wr_col, rd_col;
  logic [1:0]          chan;
  logic [5:0]          hdr_cnt;
  logic [PAD_W-1:0]    pad_cnt;
  logic [ADDR_W-1:0]   wr_addr, rd_addr;
  logic [23:0]         mem [NPIX];
  logic [23:0]         pix;
  logic                cap_beat, cap_last, xfer, row_end, pad_end;

  // Header byte lookup: each field is a little-endian word starting at 'base'.
  function automatic logic [7:0] hdr_byte(input logic [5:0] idx);
    int          i;
    int          base;
    logic [31:0] word;
    logic [1:0]  sh;
    i = int'(idx);
    word = 32'd0;
    base = i;
    if (i < 2)       begin word = 32'h0000_4D42;    base = 0;  end
    else if (i < 6)  begin word = FILE_SIZE;        base = 2;  end
    else if (i < 10) begin word = 32'd0;            base = 6;  end
    else if (i < 14) begin word = 32'd54;           base = 10; end
    else if (i < 18) begin word = 32'd40;           base = 14; end
    else if (i < 22) begin word = WIDTH;            base = 18; end
    else if (i < 26) begin word = HEIGHT;           base = 22; end
    else if (i < 28) begin word = 32'd1;            base = 26; end
    else if (i < 30) begin word = 32'd24;           base = 28; end
    else if (i < 34) begin word = 32'd0;            base = 30; end
    else if (i < 38) begin word = IMG_SIZE;         base = 34; end
    sh = 2'(i - base);
    return word[{sh, 3'b000} +: 8];
  endfunction

  assign cap_beat = HSYNC && (state == CAPTURE);
  assign cap_last = cap_beat && (wr_row == ROW_LAST) && (wr_col == COL_LAST_BEAT);
  assign xfer     = byte_valid && byte_ready;
  assign row_end  = (chan == 2'd2) && (rd_col == COL_LAST);
  assign pad_end  = (pad_cnt == PAD_LAST);
  assign wr_addr  = ADDR_W'(int'(wr_row) * WIDTH + int'(wr_col));
  assign rd_addr  = ADDR_W'(int'(rd_row) * WIDTH + int'(rd_col));
  assign pix      = mem[rd_addr];

  // Frame store write: one beat lands PIX_PER_BEAT adjacent pixels; packed {R,G,B}.
  always_ff @(posedge HCLK) begin
    if (cap_beat) begin
      for (int p = 0; p < PIX_PER_BEAT; p++) begin
        mem[wr_addr + ADDR_W'(p)] <= {DATA_R[8*p +: 8], DATA_G[8*p +: 8], DATA_B[8*p +: 8]};
      end
    end
  end

  // FSM state register.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) state <= CAPTURE;
    else         state <= state_nxt;
  end

  // Next state and byte-stream outputs; the stream holds while counters hold.
  always_comb begin
    state_nxt  = state;
    byte_valid = 1'b0;
    byte_out   = 8'd0;
    byte_last  = 1'b0;
    case (state)
      CAPTURE: begin
        if (cap_last) state_nxt = HEADER;
      end
      HEADER: begin
        byte_valid = 1'b1;
        byte_out   = hdr_byte(hdr_cnt);
        if (xfer && (hdr_cnt == HDR_LAST)) state_nxt = PIXELS;
      end
      PIXELS: begin
        byte_valid = 1'b1;
        case (chan)
          2'd0:    byte_out = pix[7:0];
          2'd1:    byte_out = pix[15:8];
          default: byte_out = pix[23:16];
        endcase
        byte_last = !HAS_PAD && row_end && (rd_row == '0);
        if (xfer && row_end) begin
          if (HAS_PAD)            state_nxt = PAD;
          else if (rd_row == '0)  state_nxt = CAPTURE;
        end
      end
      PAD: begin
        byte_valid = 1'b1;
        byte_last  = pad_end && (rd_row == '0);
        if (xfer && pad_end) state_nxt = (rd_row == '0) ? CAPTURE : PIXELS;
      end
      default: state_nxt = CAPTURE;
    endcase
  end

  // Capture/readout counters, status pulses and the sticky overrun flag.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      wr_row          <= '0;
      wr_col          <= '0;
      rd_row          <= '0;
      rd_col          <= '0;
      chan            <= '0;
      hdr_cnt         <= '0;
      pad_cnt         <= '0;
      write_done      <= 1'b0;
      write_file_done <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      write_done      <= cap_last;
      write_file_done <= xfer && byte_last;
      if (HSYNC && (state != CAPTURE)) overrun <= 1'b1;
      if (cap_beat) begin
        if (wr_col == COL_LAST_BEAT) begin
          wr_col <= '0;
          wr_row <= (wr_row == ROW_LAST) ? '0 : wr_row + ROW_W'(1);
        end else begin
          wr_col <= wr_col + COL_W'(PIX_PER_BEAT);
        end
      end
      if (xfer) begin
        case (state)
          HEADER: begin
            if (hdr_cnt == HDR_LAST) begin
              hdr_cnt <= '0;
              rd_row  <= ROW_LAST;
              rd_col  <= '0;
              chan    <= '0;
            end else begin
              hdr_cnt <= hdr_cnt + 6'd1;
            end
          end
          PIXELS: begin
            if (chan != 2'd2) begin
              chan <= chan + 2'd1;
            end else begin
              chan <= '0;
              if (rd_col == COL_LAST) begin
                rd_col <= '0;
                if (!HAS_PAD && (rd_row != '0)) rd_row <= rd_row - ROW_W'(1);
              end else begin
                rd_col <= rd_col + COL_W'(1);
              end
            end
          end
          PAD: begin
            if (pad_end) begin
              pad_cnt <= '0;
              if (rd_row != '0) rd_row <= rd_row - ROW_W'(1);
            end else begin
              pad_cnt <= pad_cnt + PAD_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
